// File: rtl/dvi_rx_tmds_dec.sv
// -----------------------------------------------------------------------------
// dvi_rx_tmds_dec
// Receive-side TMDS decoder for one DVI channel. It finds the 10-bit word
// boundary in the free-running deserializer stream by hunting for runs of
// control tokens at each bit offset. It then decodes every aligned word into
// pixel data or a control value.
//
// Optional feature (macro DVI_RX_LOCK_LOSS_CNT_EN):
//   defined   : lock_loss_cnt counts LOCKED->SEARCH transitions and
//               saturates at 16'hFFFF
//   undefined : lock_loss_cnt is tied to zero
//
// Ports:
//   clock         in   channel pixel clock
//   reset         in   asynchronous, active-high reset
//   tmds_in[9:0]  in   raw deserializer word, bit 0 = earliest serial bit
//   den           out  1 = data word decoded, 0 = control or unlocked
//   data[7:0]     out  decoded pixel byte
//   ctrl[1:0]     out  decoded control value {c1,c0}
//   locked        out  word alignment achieved
//   offset[3:0]   out  current bit offset, 0..9
//   lock_loss_cnt out  lock-loss event counter (optional feature)
// -----------------------------------------------------------------------------
module dvi_rx_tmds_dec #(
  parameter int SEARCH_WIN = 4096,
  parameter int CTRL_RUN   = 8,
  parameter int LOSS_WIN   = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  tmds_in,
  output logic        den,
  output logic [7:0]  data,
  output logic [1:0]  ctrl,
  output logic        locked,
  output logic [3:0]  offset,
  output logic [15:0] lock_loss_cnt
);

  localparam int TR_W = $clog2(CTRL_RUN + 1);
  localparam int SC_W = $clog2(SEARCH_WIN + 1);
  localparam int GC_W = $clog2(LOSS_WIN + 1);
  localparam logic [TR_W-1:0] TR_MAX  = TR_W'(CTRL_RUN);
  localparam logic [TR_W-1:0] TR_LAST = TR_W'(CTRL_RUN - 1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(SEARCH_WIN);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SEARCH_WIN - 1);
  localparam logic [GC_W-1:0] GC_MAX  = GC_W'(LOSS_WIN);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(LOSS_WIN - 1);

  typedef enum logic [0:0] {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

  // Token lookup: returns {hit, value}.
  function automatic logic [2:0] tok_lookup(input logic [9:0] w);
    logic [2:0] r;
    case (w)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  // Undo the TMDS transition-minimising encoding of a data word.
  function automatic logic [7:0] tmds_data(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] q;
    d    = w[9] ? ~w[7:0] : w[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  logic [9:0]      w0_r, w1_r;
  logic [19:0]     cat_s;
  logic [9:0]      aligned_s;
  logic [2:0]      tok_s;
  logic [7:0]      q_s;
  state_t          state_r, state_nxt_s;
  logic [TR_W-1:0] tok_run_r, tok_run_nxt_s;
  logic [SC_W-1:0] srch_cnt_r, srch_cnt_nxt_s;
  logic [GC_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic [3:0]      offset_r, offset_nxt_s;
  logic            den_nxt_s, locked_nxt_s;
  logic [7:0]      data_nxt_s;
  logic [1:0]      ctrl_nxt_s;
  logic            den_r, locked_r;
  logic [7:0]      data_r;
  logic [1:0]      ctrl_r;

  assign cat_s  = {w0_r, w1_r};
  assign tok_s  = tok_lookup(aligned_s);
  assign q_s    = tmds_data(aligned_s);
  assign den    = den_r;
  assign data   = data_r;
  assign ctrl   = ctrl_r;
  assign locked = locked_r;
  assign offset = offset_r;

  // Two-word capture pipeline feeding the barrel selector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w0_r <= 10'd0;
      w1_r <= 10'd0;
    end else begin
      w0_r <= tmds_in;
      w1_r <= w0_r;
    end
  end

  // Select the 10-bit window at the current bit offset (older word in low bits).
  always_comb begin
    aligned_s = cat_s[9:0];
    case (offset_r)
      4'd0:    aligned_s = cat_s[9:0];
      4'd1:    aligned_s = cat_s[10:1];
      4'd2:    aligned_s = cat_s[11:2];
      4'd3:    aligned_s = cat_s[12:3];
      4'd4:    aligned_s = cat_s[13:4];
      4'd5:    aligned_s = cat_s[14:5];
      4'd6:    aligned_s = cat_s[15:6];
      4'd7:    aligned_s = cat_s[16:7];
      4'd8:    aligned_s = cat_s[17:8];
      4'd9:    aligned_s = cat_s[18:9];
      default: aligned_s = cat_s[9:0];
    endcase
  end

  // FSM state, counters and offset register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_SEARCH;
      tok_run_r  <= '0;
      srch_cnt_r <= '0;
      gap_cnt_r  <= '0;
      offset_r   <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      tok_run_r  <= tok_run_nxt_s;
      srch_cnt_r <= srch_cnt_nxt_s;
      gap_cnt_r  <= gap_cnt_nxt_s;
      offset_r   <= offset_nxt_s;
    end
  end

  // Next-state logic: token-run hunt per offset, gap watchdog while locked.
  always_comb begin
    state_nxt_s    = state_r;
    tok_run_nxt_s  = tok_run_r;
    srch_cnt_nxt_s = srch_cnt_r;
    gap_cnt_nxt_s  = gap_cnt_r;
    offset_nxt_s   = offset_r;
    case (state_r)
      ST_SEARCH: begin
        if (tok_s[2]) begin
          tok_run_nxt_s = (tok_run_r == TR_MAX) ? TR_MAX : tok_run_r + TR_W'(1);
        end else begin
          tok_run_nxt_s = '0;
        end
        srch_cnt_nxt_s = (srch_cnt_r == SC_MAX) ? SC_MAX : srch_cnt_r + SC_W'(1);
        // Lock takes priority over an offset advance in the same cycle.
        if (tok_s[2] && (tok_run_r == TR_LAST)) begin
          state_nxt_s   = ST_LOCKED;
          gap_cnt_nxt_s = '0;
        end else if (srch_cnt_r == SC_LAST) begin
          offset_nxt_s   = (offset_r == 4'd9) ? 4'd0 : offset_r + 4'd1;
          tok_run_nxt_s  = '0;
          srch_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end
      ST_LOCKED: begin
        if (tok_s[2]) begin
          gap_cnt_nxt_s = '0;
        end else begin
          gap_cnt_nxt_s = (gap_cnt_r == GC_MAX) ? GC_MAX : gap_cnt_r + GC_W'(1);
        end
        if (!tok_s[2] && (gap_cnt_r == GC_LAST)) begin
          state_nxt_s    = ST_SEARCH;
          tok_run_nxt_s  = '0;
          srch_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_SEARCH;
      end
    endcase
  end

  // Output decode; uses the post-update lock state so the locking token and
  // the lock-losing word already show their new form.
  always_comb begin
    locked_nxt_s = (state_nxt_s == ST_LOCKED);
    den_nxt_s    = 1'b0;
    data_nxt_s   = 8'd0;
    ctrl_nxt_s   = 2'd0;
    if (locked_nxt_s) begin
      if (tok_s[2]) begin
        ctrl_nxt_s = tok_s[1:0];
      end else begin
        den_nxt_s  = 1'b1;
        data_nxt_s = q_s;
        ctrl_nxt_s = ctrl_r;
      end
    end else begin
      den_nxt_s = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      den_r    <= 1'b0;
      data_r   <= 8'd0;
      ctrl_r   <= 2'd0;
      locked_r <= 1'b0;
    end else begin
      den_r    <= den_nxt_s;
      data_r   <= data_nxt_s;
      ctrl_r   <= ctrl_nxt_s;
      locked_r <= locked_nxt_s;
    end
  end

`ifdef DVI_RX_LOCK_LOSS_CNT_EN
  logic [15:0] lock_loss_cnt_r;

  assign lock_loss_cnt = lock_loss_cnt_r;

  // Saturating count of LOCKED->SEARCH transitions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_loss_cnt_r <= 16'd0;
    end else if ((state_r == ST_LOCKED) && (state_nxt_s == ST_SEARCH) &&
                 (lock_loss_cnt_r != 16'hFFFF)) begin
      lock_loss_cnt_r <= lock_loss_cnt_r + 16'd1;
    end else begin
      lock_loss_cnt_r <= lock_loss_cnt_r;
    end
  end
`else
  assign lock_loss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dvi_rx_tmds_dec.sv
module tb_dvi_rx_tmds_dec;

  localparam int SW = 64;
  localparam int CR = 8;
  localparam int LW = 16;

  logic        clock;
  logic        reset;
  logic [9:0]  tmds_in;
  logic        den;
  logic [7:0]  data;
  logic [1:0]  ctrl;
  logic        locked;
  logic [3:0]  offset;
  logic [15:0] lock_loss_cnt;

  int n_checks;
  int n_errors;

  // reference model state
  logic [9:0] m_w0, m_w1;
  int         m_locked, m_run, m_srch, m_gap, m_off, m_loss;
  logic       e_den;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;

  dvi_rx_tmds_dec #(.SEARCH_WIN(SW), .CTRL_RUN(CR), .LOSS_WIN(LW)) dut (
    .clock(clock), .reset(reset), .tmds_in(tmds_in), .den(den), .data(data),
    .ctrl(ctrl), .locked(locked), .offset(offset), .lock_loss_cnt(lock_loss_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_llc();
`ifdef DVI_RX_LOCK_LOSS_CNT_EN
    return 16'(m_loss);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_reset();
    m_w0 = 10'd0; m_w1 = 10'd0;
    m_locked = 0; m_run = 0; m_srch = 0; m_gap = 0; m_off = 0; m_loss = 0;
    e_den = 1'b0; e_data = 8'd0; e_ctrl = 2'd0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic [9:0] word);
    logic [19:0] cat;
    logic [9:0]  al;
    logic [7:0]  d, q;
    logic [1:0]  tv;
    int          tok;
    cat = {m_w0, m_w1};
    al  = 10'(cat >> m_off);
    tok = 1;
    case (al)
      10'h354: tv = 2'd0;
      10'h0AB: tv = 2'd1;
      10'h154: tv = 2'd2;
      10'h2AB: tv = 2'd3;
      default: begin tok = 0; tv = 2'd0; end
    endcase
    d = al[9] ? ~al[7:0] : al[7:0];
    q = d ^ {d[6:0], 1'b0} ^ (al[8] ? 8'h00 : 8'hFE);
    if (m_locked == 0) begin
      m_srch++;
      m_run = tok ? m_run + 1 : 0;
      if (m_run == CR) begin
        m_locked = 1; m_gap = 0;
      end else if (m_srch == SW) begin
        m_off = (m_off + 1) % 10; m_run = 0; m_srch = 0;
      end
    end else begin
      m_gap = tok ? 0 : m_gap + 1;
      if (m_gap == LW) begin
        m_locked = 0; m_run = 0; m_srch = 0;
        if (m_loss < 65535) m_loss++;
      end
    end
    if (m_locked == 0) begin
      e_den = 1'b0; e_data = 8'd0; e_ctrl = 2'd0;
    end else if (tok != 0) begin
      e_den = 1'b0; e_data = 8'd0; e_ctrl = tv;
    end else begin
      e_den = 1'b1; e_data = q;
    end
    m_w1 = m_w0;
    m_w0 = word;
  endtask

  task automatic step(input logic [9:0] word);
    tmds_in = word;
    @(posedge clock);
    #1;
    model_edge(word);
    chk("den",    16'(den),    16'(e_den));
    chk("data",   16'(data),   16'(e_data));
    chk("ctrl",   16'(ctrl),   16'(e_ctrl));
    chk("locked", 16'(locked), 16'(m_locked));
    chk("offset", 16'(offset), 16'(m_off));
    chk("llc",    lock_loss_cnt, exp_llc());
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_den",    16'(den),    16'd0);
    chk("rst_data",   16'(data),   16'd0);
    chk("rst_ctrl",   16'(ctrl),   16'd0);
    chk("rst_locked", 16'(locked), 16'd0);
    chk("rst_offset", 16'(offset), 16'd0);
    chk("rst_llc",    lock_loss_cnt, 16'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  logic [9:0] toks [4];
  logic [9:0] tx_prev, tx_cur;
  int         seen;

  initial begin
    n_checks = 0; n_errors = 0;
    toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
    tmds_in = 10'd0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("init_locked", 16'(locked), 16'd0);
    @(posedge clock);
    #3;
    reset = 1'b0;

    // aligned stream: lock on the 8th token, then data 0x00 and 0xFF
    for (int i = 0; i < 10; i++) begin
      step(10'h354);
      if (i == 8) chk("pre_lock", 16'(locked), 16'd0);
      if (i == 9) chk("lock_8th", 16'(locked), 16'd1);
    end
    step(10'h100);
    step(10'h200);
    step(10'h354);
    chk("d100_den", 16'(den), 16'd1);
    chk("d100_data", 16'(data), 16'h00);
    step(10'h354);
    chk("d200_data", 16'(data), 16'hFF);

    // each of the other tokens
    for (int t = 1; t < 4; t++) begin
      for (int i = 0; i < 10; i++) step(toks[t]);
      chk("tok_ctrl", 16'(ctrl), 16'(t));
      chk("tok_den", 16'(den), 16'd0);
    end

    // random mix of tokens and arbitrary words
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) step(toks[$urandom_range(0, 3)]);
      else step(10'($urandom));
    end

    // async reset while the stream is active
    for (int i = 0; i < 10; i++) step(10'h354);
    step(10'h1C3);
    step(10'h354);
    do_reset();

    // lock loss and relock
    for (int i = 0; i < 10; i++) step(10'h354);
    chk("ll_locked0", 16'(locked), 16'd1);
    for (int i = 0; i < 16; i++) step(10'h100);
    step(10'h354);
    chk("ll_still", 16'(locked), 16'd1);
    step(10'h354);
    chk("ll_fall", 16'(locked), 16'd0);
    chk("ll_den", 16'(den), 16'd0);
    chk("ll_off", 16'(offset), 16'd0);
`ifdef DVI_RX_LOCK_LOSS_CNT_EN
    chk("ll_cnt", lock_loss_cnt, 16'd1);
`else
    chk("ll_cnt", lock_loss_cnt, 16'd0);
`endif
    for (int i = 0; i < 10; i++) step(10'h354);
    chk("relock", 16'(locked), 16'd1);

    // misaligned stream delayed by 3 serial bits
    do_reset();
    tx_prev = 10'd0;
    seen = 0;
    for (int n = 0; n < 11 * SW && seen == 0; n++) begin
      tx_cur = ((n / 32) % 2 == 0) ? 10'h354 : 10'h100;
      step({tx_cur[6:0], tx_prev[9:7]});
      tx_prev = tx_cur;
      if (locked) seen = n + 1;
    end
    chk("mis_locked", 16'(locked), 16'd1);
    chk("mis_offset", 16'(offset), 16'd3);
    chk("mis_ctrl", 16'(ctrl), 16'd0);
    for (int n = seen; n < seen + 12; n++) begin
      tx_cur = ((n / 32) % 2 == 0) ? 10'h354 : 10'h100;
      step({tx_cur[6:0], tx_prev[9:7]});
      tx_prev = tx_cur;
      if (den) chk("mis_data", 16'(data), 16'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dvi_rx_tmds_dec.md
Name: dvi_rx_tmds_dec

Overview:
- Receive-side TMDS decoder for one DVI channel. Sits after the 10:1 deserializer and before the channel-deskew and pixel-sync logic.
- Takes a free-running 10-bit word whose boundary is arbitrary, finds the word boundary by hunting for control tokens, then decodes each aligned word to either 8-bit pixel data or a 2-bit control value.
- Reports lock state and the selected bit offset.

Parameters:
- SEARCH_WIN, 4096: words examined at one bit offset before advancing to the next offset.
- CTRL_RUN, 8: consecutive control tokens needed to declare lock.
- LOSS_WIN, 4096: consecutive non-token words while locked that force loss of lock.

Ports:
- clock  in  1  channel pixel clock.
- reset  in  1  asynchronous, active-high reset.
- tmds_in  in  10  raw deserializer word; bit 0 is the earliest serial bit.
- den  out  1  1 = data word decoded, 0 = control or unlocked.
- data  out  8  decoded pixel byte.
- ctrl  out  2  decoded control value, ordered {c1,c0}.
- locked  out  1  word alignment achieved.
- offset  out  4  current bit offset, 0..9.
- lock_loss_cnt  out  16  lock-loss event counter (optional feature).

Behaviour:
- Reset is asynchronous. It clears all registers. Reset values: den=0, data=0, ctrl=0, locked=0, offset=0, lock_loss_cnt=0; FSM=SEARCH; all counters 0. Reset asserted mid-operation drops all outputs immediately.
- Pipeline:
  - w0 <= tmds_in; w1 <= w0.
  - cat = {w0,w1} (20 bits).
  - aligned = cat[offset+9 : offset].
  - The output register and FSM update on the edge after aligned is formed.
  - A word sampled into w0 at edge k reaches the outputs at edge k+2 when offset=0.
- Control tokens (aligned word → ctrl): 10'b1101010100 → 00; 10'b0010101011 → 01; 10'b0101010100 → 10; 10'b1010101011 → 11.
- Data decode:
  - d = aligned[9] ? ~aligned[7:0] : aligned[7:0].
  - q[0] = d[0].
  - For i = 1..7: q[i] = aligned[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Output update while locked:
  - Token word: den=0, ctrl=token value, data=0.
  - Any other word: den=1, data=q, ctrl holds its last value.
- Output update while not locked: den=0, data=0, ctrl=0.
- FSM state SEARCH:
  - Token word: tok_run+1. Otherwise tok_run=0.
  - srch_cnt increments every word.
  - When tok_run reaches CTRL_RUN, go to LOCKED, gap_cnt=0. locked=1 and the decoded ctrl of that CTRL_RUN-th token appear on the same edge.
  - Otherwise, when srch_cnt == SEARCH_WIN-1, set offset = (offset==9) ? 0 : offset+1 and clear tok_run and srch_cnt. The new offset takes effect on the next word; there is no settle cycle.
  - Lock and offset advance in the same cycle: lock wins and offset is unchanged.
- FSM state LOCKED:
  - Token word: gap_cnt=0. Otherwise gap_cnt+1.
  - When gap_cnt reaches LOSS_WIN, go to SEARCH with offset kept, tok_run=srch_cnt=0, locked=0. That word's output is the unlocked form.
- Counter widths are $clog2(param+1). Counters saturate at their terminal values and never wrap.

Optional Feature:
- DVI_RX_LOCK_LOSS_CNT_EN defined: lock_loss_cnt increments by 1 on every LOCKED→SEARCH transition and saturates at 16'hFFFF. Only reset clears it.
- Not defined: lock_loss_cnt is tied to 0 and no counter logic is built.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert reset mid-stream with outputs active → den, data, ctrl, locked, offset go to 0 immediately, without waiting for a clock edge.
- Aligned stream, CTRL_RUN=8: 10 words 10'b1101010100, then 0x100, then 0x200 → locked rises with the 8th ctrl=00 output; following outputs are den=1 data=0x00, then den=1 data=0xFF.
- Tokens 0x0AB, 0x154, 0x2AB (each repeated ≥8 times) after lock → ctrl=01, 10, 11 respectively, den=0, data=0.
- Misaligned stream, SEARCH_WIN=64: 32 ctrl=00 token words alternating with 32 words 0x100, delayed 3 serial bits (received word = {tx[n][6:0], tx[n-1][9:7]}) → locked within 10×64 words with offset=3; decoded data is 0x00 and ctrl is 00.
- Lock loss, LOSS_WIN=16, macro defined: after lock, send 16 consecutive 0x100 words → locked falls on the 16th word, den=0, offset unchanged, lock_loss_cnt=1. Resuming tokens relocks after 8 tokens.
- Macro undefined: repeat the lock-loss scenario → lock_loss_cnt stays 0; every other output is identical to the macro-defined run.
